// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Booth recoding of the pair {Q[0], Q_1}; 00 and 11 leave A untouched
   localparam logic [1:0] ADD = 2'b01;
   localparam logic [1:0] SUB = 2'b10;

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_multiplier_if #(
   parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

   logic                      start;
   logic signed [WIDTH-1:0]   multiplicand;
   logic signed [WIDTH-1:0]   multiplier;
   logic                      busy;
   logic                      done;
   logic signed [2*WIDTH-1:0] product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );

endinterface

// File: rtl/booth_multiplier_step.sv
// One combinational Booth step: conditional add/subtract of M, then an
// arithmetic shift right of {A, Q, Q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic signed [WIDTH:0]   a,
   input  logic        [WIDTH-1:0] q,
   input  logic                    q_1,
   input  logic signed [WIDTH:0]   m,
   output logic signed [WIDTH:0]   a_next,
   output logic        [WIDTH-1:0] q_next,
   output logic                    q_1_next
);

   logic signed [WIDTH:0] sum;

   // A is one bit wider than the operands, so A +/- M cannot overflow
   always_comb begin
      sum = a;
      case ({q[0], q_1})
         ADD:     sum = a + m;
         SUB:     sum = a - m;
         default: sum = a;
      endcase
   end

   assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
   assign q_next   = {sum[0], q[WIDTH-1:1]};
   assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier: one step per clock, WIDTH steps
// per operation, result held until the next completion.
module booth_multiplier
   import booth_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   booth_multiplier_if.slave bus
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t                    state;
   state_t                    state_next;
   logic signed [WIDTH:0]     a_reg;
   logic signed [WIDTH:0]     m_reg;
   logic        [WIDTH-1:0]   q_reg;
   logic                      q_1_reg;
   logic        [CW-1:0]      count;
   logic                      done_reg;
   logic signed [2*WIDTH-1:0] product_reg;

   logic signed [WIDTH:0]     a_next;
   logic        [WIDTH-1:0]   q_next;
   logic                      q_1_next;

   logic                      load;
   logic                      step;
   logic                      last;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a        (a_reg),
      .q        (q_reg),
      .q_1      (q_1_reg),
      .m        (m_reg),
      .a_next   (a_next),
      .q_next   (q_next),
      .q_1_next (q_1_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (count == LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // start is only honoured in IDLE, so a request during RUN is dropped
   always_comb begin
      load = 1'b0;
      step = 1'b0;
      last = 1'b0;
      case (state)
         IDLE:    load = bus.start;
         RUN: begin
            step = 1'b1;
            last = (count == LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         m_reg       <= '0;
         q_reg       <= '0;
         q_1_reg     <= 1'b0;
         count       <= '0;
         done_reg    <= 1'b0;
         product_reg <= '0;
      end else begin
         done_reg <= last;
         if (load) begin
            m_reg   <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
            a_reg   <= '0;
            q_reg   <= bus.multiplier;
            q_1_reg <= 1'b0;
            count   <= '0;
         end else if (step) begin
            a_reg   <= a_next;
            q_reg   <= q_next;
            q_1_reg <= q_1_next;
            count   <= count + CW'(1);
         end
         // The final step's shifted {A, Q} is the product
         if (last) product_reg <= {a_next[WIDTH-1:0], q_next};
      end
   end

   assign bus.busy    = (state == RUN);
   assign bus.done    = done_reg;
   assign bus.product = product_reg;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed testbench for booth_multiplier: hand-computed products, latency,
// start-ignored-while-busy and mid-operation reset.
module tb_booth_multiplier;

   logic clk;
   logic rst;
   int   vectorCount;
   int   missCount;

   booth_multiplier_if #(.WIDTH(8)) bus ();

   booth_multiplier #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Called right after the start edge has passed; counts edges until done
   task automatic waitDone(output int edges, output bit busyHeld);
      edges    = 0;
      busyHeld = 1'b1;
      while (!bus.done && edges < 20) begin
         if (!bus.busy) busyHeld = 1'b0;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic applyStimulus(input string tag, input logic signed [7:0] m,
                                input logic signed [7:0] q,
                                input logic signed [15:0] expected);
      int edges;
      bit busyHeld;
      @(negedge clk);
      bus.multiplicand = m;
      bus.multiplier   = q;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(edges, busyHeld);
      checkOutput({tag, "_latency"}, edges, 8);
      checkOutput({tag, "_busy"}, busyHeld, 1);
      checkOutput({tag, "_product"}, bus.product, expected);
      @(negedge clk);
      checkOutput({tag, "_donepulse"}, bus.done, 0);
   endtask

   initial begin
      int  edges;
      bit  busyHeld;
      bit  sawDone;
      vectorCount      = 0;
      missCount        = 0;
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_product", bus.product, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_busy", bus.busy, 0);

      applyStimulus("p13x3",   8'sd13,   8'sd3,   16'sd39);
      applyStimulus("m5x4",   -8'sd5,    8'sd4,  -16'sd20);
      applyStimulus("p7xm6",   8'sd7,   -8'sd6,  -16'sd42);
      applyStimulus("m8xm2",  -8'sd8,   -8'sd2,   16'sd16);
      applyStimulus("p127x1",  8'sd127,  8'sd1,   16'sd127);
      applyStimulus("p0xm5",   8'sd0,   -8'sd5,   16'sd0);
      applyStimulus("m128xm128", -8'sd128, -8'sd128, 16'sd16384);
      applyStimulus("m128x127",  -8'sd128,  8'sd127, -16'sd16256);
      applyStimulus("p127x127",   8'sd127,  8'sd127,  16'sd16129);
      applyStimulus("m1xm1",     -8'sd1,   -8'sd1,    16'sd1);

      // A second start with new operands during RUN must be ignored
      @(negedge clk);
      bus.multiplicand = 8'sd13;
      bus.multiplier   = 8'sd3;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.multiplicand = 8'sd7;
      bus.multiplier   = -8'sd6;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waitDone(edges, busyHeld);
      checkOutput("ignore_latency", edges, 5);
      checkOutput("ignore_product", bus.product, 39);
      repeat (4) @(negedge clk);
      checkOutput("ignore_no_rerun", bus.busy, 0);
      checkOutput("ignore_hold", bus.product, 39);

      // Product holds through the next RUN until that one completes
      bus.multiplicand = -8'sd8;
      bus.multiplier   = -8'sd2;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("hold_midrun", bus.product, 39);
      waitDone(edges, busyHeld);
      checkOutput("hold_next_product", bus.product, 16);

      // Reset before step 4 aborts the operation
      @(negedge clk);
      bus.multiplicand = 8'sd127;
      bus.multiplier   = 8'sd1;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", bus.busy, 0);
      checkOutput("abort_product", bus.product, 0);
      checkOutput("abort_done", bus.done, 0);
      @(negedge clk);
      rst     = 1'b0;
      sawDone = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) sawDone = 1'b1;
      end
      checkOutput("abort_no_done", sawDone, 0);
      checkOutput("abort_product_held", bus.product, 0);
      applyStimulus("after_abort", -8'sd5, 8'sd4, -16'sd20);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
